conv2_k_g2_fetch: RTL and testbench

Read-side controller for the conv2 group-2 kernel weight ROM. It drives both ROM address ports and streams the weights out as 32-bit word pairs on a valid/ready interface toward the conv2 MAC array. It absorbs the ROM's one-cycle registered read latency and downstream backpressure through a 2-entry output buffer, and it sustains one pair per cycle when the consumer never stalls.

---
 rtl/conv2_fetch_pkg.sv | 12 +
 rtl/pair_fifo2.sv | 50 +++++
 rtl/conv2_k_g2_fetch.sv | 101 ++++++++++
 tb/tb_conv2_k_g2_fetch.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_fetch_pkg.sv
// Shared widths and FSM encoding for the conv2 group-2 kernel weight fetch path.
package conv2_fetch_pkg;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 8;
  localparam int ROM_DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/pair_fifo2.sv
// Two-entry FIFO with registered head; push and pop in one cycle are both honoured.
// Zero-latency head after first push; the caller must never push into a full buffer.
module pair_fifo2
  import conv2_fetch_pkg::*;
#(
  parameter int W = 2 * DATA_W + 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head_data
);
  logic [W-1:0] tail_q;
  logic         do_pop;

  assign do_pop = pop && (count != 2'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count     <= 2'd0;
      head_data <= '0;
      tail_q    <= '0;
    end else begin
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) head_data <= push_data;
          else               tail_q    <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          head_data <= tail_q;
          count     <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new word lands behind whatever remains.
          if (count == 2'd1) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_q;
            tail_q    <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/conv2_k_g2_fetch.sv
// Streams kernel weight pairs from a dual-address ROM onto a valid/ready bus.
// First pair three cycles after start; credit-gated issue keeps the 2-entry buffer from overflowing.
module conv2_k_g2_fetch
  import conv2_fetch_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W-2:0]   len_m1,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   rom_address_a,
  output logic [ADDR_W-1:0]   rom_address_b,
  input  logic [DATA_W-1:0]   rom_q_a,
  input  logic [DATA_W-1:0]   rom_q_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*DATA_W-1:0] out_data,
  output logic                out_last
);
  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-2:0] len_q;
  logic [ADDR_W-2:0] idx_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic              inflight, last_inflight;
  logic [1:0]        count;
  logic [2:0]        load;
  logic              pop, issue, issue_last;
  logic [2*DATA_W:0] head;

  assign pop        = out_valid && out_ready;
  assign issue_last = (idx_q == len_q);

  // Occupancy after this cycle's pop plus the word still coming back from the ROM.
  assign load  = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
  assign issue = (state == RUN) && (load < 3'd2);

  // Addresses are live in the issue cycle so the ROM samples them at the next edge.
  assign rom_address_a = issue ? base_q + {idx_q, 1'b0} : addr_a_q;
  assign rom_address_b = issue ? base_q + {idx_q, 1'b1} : addr_b_q;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (issue && issue_last) state_nxt = DRAIN;
      DRAIN: begin
        if ((count == 2'd0) && !inflight) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE) && !done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      addr_a_q      <= '0;
      addr_b_q      <= '0;
      inflight      <= 1'b0;
      last_inflight <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr_a_q      <= rom_address_a;
      addr_b_q      <= rom_address_b;
      inflight      <= issue;
      last_inflight <= issue && issue_last;
      if ((state == IDLE) && start) begin
        base_q <= base;
        len_q  <= len_m1;
        idx_q  <= '0;
      end else if (issue) begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  pair_fifo2 #(.W(2 * DATA_W + 1)) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data ({last_inflight, rom_q_b, rom_q_a}),
    .pop       (pop),
    .count     (count),
    .head_data (head)
  );

  assign out_valid = (count != 2'd0);
  assign out_last  = head[2*DATA_W];
  assign out_data  = head[2*DATA_W-1:0];
endmodule

// File: tb/tb_conv2_k_g2_fetch.sv
// Randomized scoreboard bench for conv2_k_g2_fetch with a behavioural ROM.
module tb_conv2_k_g2_fetch;
  import conv2_fetch_pkg::*;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base = '0;
  logic [ADDR_W-2:0]   len_m1 = '0;
  logic                busy, done;
  logic [ADDR_W-1:0]   rom_address_a, rom_address_b;
  logic [DATA_W-1:0]   rom_q_a, rom_q_b;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [2*DATA_W-1:0] out_data;
  logic                out_last;

  conv2_k_g2_fetch dut (
    .clock(clock), .reset_n(reset_n), .start(start), .base(base), .len_m1(len_m1),
    .busy(busy), .done(done), .rom_address_a(rom_address_a), .rom_address_b(rom_address_b),
    .rom_q_a(rom_q_a), .rom_q_b(rom_q_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clock = ~clock;

  logic [DATA_W-1:0] rom [ROM_DEPTH];
  always @(posedge clock) begin
    rom_q_a <= rom[rom_address_a];
    rom_q_b <= rom[rom_address_b];
  end

  typedef struct {
    logic [2*DATA_W-1:0] d;
    logic                l;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int ncount = 0, t_start = 0;
  int first_valid_rel = -1, last_hs_rel = -1, done_rel = -1;
  int done_count = 0, exp_done = 0, hs_count = 0;
  logic busy_at_done = 1'b0;
  bit rand_ready = 1'b0;
  logic ready_level = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: pair k reads words (base+2k) and (base+2k+1) modulo the ROM depth.
  task automatic push_expected(input int b, input int n);
    for (int k = 0; k <= n; k++) begin
      exp_t e;
      int a0, a1;
      a0 = (b + 2 * k) % ROM_DEPTH;
      a1 = (b + 2 * k + 1) % ROM_DEPTH;
      e.d = {16'(32'hA000 + a1), 16'(32'hA000 + a0)};
      e.l = (k == n);
      exp_q.push_back(e);
    end
  endtask

  task automatic issue_start(input int b, input int n, input bit accept);
    @(posedge clock);
    #1;
    start  = 1'b1;
    base   = ADDR_W'(b);
    len_m1 = (ADDR_W-1)'(n);
    @(posedge clock);
    #1;
    start = 1'b0;
    if (accept) begin
      push_expected(b, n);
      t_start = ncount;
      first_valid_rel = -1;
      last_hs_rel = -1;
      done_rel = -1;
      exp_done++;
    end
  endtask

  task automatic wait_done(input string name);
    for (int c = 0; c < 3000 && done_count < exp_done; c++) @(negedge clock);
    @(negedge clock);
    check(name, 64'(done_count), 64'(exp_done));
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_valid"}, 64'(out_valid), 64'd0);
    check({name, "_last"}, 64'(out_last), 64'd0);
    check({name, "_data"}, 64'(out_data), 64'd0);
    check({name, "_addr_a"}, 64'(rom_address_a), 64'd0);
    check({name, "_addr_b"}, 64'(rom_address_b), 64'd0);
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  end

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  initial begin
    logic stall_prev;
    logic [2*DATA_W:0] held;
    int rel;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clock);
      ncount++;
      rel = ncount - t_start;
      if (!reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (out_valid && first_valid_rel < 0) first_valid_rel = rel;
        if (stall_prev)
          check("hold_while_stalled", {31'd0, out_valid, out_last, out_data}, {31'd0, 1'b1, held});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pair actual=%h required=none", {out_last, out_data});
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("pair", {31'd0, out_last, out_data}, {31'd0, e.l, e.d});
          end
          hs_count++;
          if (out_last) last_hs_rel = rel;
        end
        stall_prev = out_valid && !out_ready;
        held = {out_last, out_data};
        if (done) begin
          done_count++;
          done_rel = rel;
          busy_at_done = busy;
        end
      end
    end
  end

  initial begin
    int hs0, dc0, b, n;
    for (int k = 0; k < ROM_DEPTH; k++) rom[k] = 16'(32'hA000 + k);

    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Single pair with exact cycle timing.
    issue_start(8'h10, 0, 1);
    @(negedge clock);
    check("single_busy_c1", 64'(busy), 64'd1);
    check("single_addr_a_c1", 64'(rom_address_a), 64'h10);
    check("single_addr_b_c1", 64'(rom_address_b), 64'h11);
    wait_done("single_done");
    check("single_first_valid_cycle", 64'(first_valid_rel), 64'd3);
    check("single_last_cycle", 64'(last_hs_rel), 64'd3);
    check("single_done_cycle", 64'(done_rel), 64'd4);
    check("single_busy_at_done", 64'(busy_at_done), 64'd0);

    // Full 128-pair burst; a late last handshake would expose a bubble.
    issue_start(0, 127, 1);
    wait_done("full_done");
    check("full_first_valid_cycle", 64'(first_valid_rel), 64'd3);
    check("full_last_cycle", 64'(last_hs_rel), 64'd130);
    check("full_done_cycle", 64'(done_rel), 64'd131);

    issue_start(8'hFE, 1, 1);
    wait_done("wrap_done");
    check("wrap_last_cycle", 64'(last_hs_rel), 64'd4);

    rand_ready = 1'b1;
    issue_start(8'h21, 15, 1);
    wait_done("backpressure_done");

    // Second start mid-burst must leave no trace.
    issue_start(8'h20, 15, 1);
    repeat (6) @(posedge clock);
    issue_start(8'h40, 3, 0);
    wait_done("busy_start_done");
    repeat (20) @(negedge clock);
    check("busy_start_single_done", 64'(done_count), 64'(exp_done));

    for (int r = 0; r < 4; r++) begin
      b = int'($urandom_range(0, 255));
      n = int'($urandom_range(0, 20));
      issue_start(b, n, 1);
      wait_done("random_done");
    end

    // Reset in the middle of a burst, then a clean restart.
    rand_ready = 1'b0;
    hs0 = hs_count;
    issue_start(8'h80, 31, 1);
    for (int c = 0; c < 500 && hs_count < hs0 + 5; c++) @(negedge clock);
    check("midreset_pairs_seen", 64'(hs_count - hs0 >= 5), 64'd1);
    dc0 = done_count;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_done = dc0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("midreset_no_done", 64'(done_count), 64'(dc0));
    issue_start(8'h33, 3, 1);
    wait_done("restart_done");
    check("restart_first_valid_cycle", 64'(first_valid_rel), 64'd3);
    repeat (10) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
